// File: rtl/pit_pkg.sv
// Shared 8254 definitions: RW encodings, control-word address and field positions.
package pit_pkg;

  localparam logic [1:0] RW_LATCH  = 2'b00;
  localparam logic [1:0] RW_LSB    = 2'b01;
  localparam logic [1:0] RW_MSB    = 2'b10;
  localparam logic [1:0] RW_WORD   = 2'b11;

  localparam logic [1:0] CTRL_ADDR   = 2'b11;
  localparam logic [1:0] SC_READBACK = 2'b11;

  localparam int unsigned CW_SC_HI = 7;
  localparam int unsigned CW_SC_LO = 6;
  localparam int unsigned CW_RW_HI = 5;
  localparam int unsigned CW_RW_LO = 4;
  localparam int unsigned CW_M_HI  = 3;
  localparam int unsigned CW_M_LO  = 1;
  localparam int unsigned CW_BCD   = 0;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned COUNT_W = 16;

  // Modes 6/7 are aliases of 2/3 on the 8254.
  function automatic logic [2:0] fold_mode(input logic [2:0] m);
    return m[1] ? {1'b0, m[1:0]} : m;
  endfunction

endpackage

// File: rtl/counter_rw_port_if.sv
// CPU-side 8254 data bus as seen by one counter's read/write port.
interface counter_rw_port_if;
  logic       cs;
  logic       wr;
  logic       rd;
  logic [1:0] a;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output cs, wr, rd, a, din, input dout);
  modport slave  (input cs, wr, rd, a, din, output dout);
endinterface

// File: rtl/counter_rw_port.sv
// CPU read/write logic for one 8254 counter: control-word decode, count byte
// assembly, load strobe, counter latch and (with PIT_READBACK_EN) read-back
// status latch.
module counter_rw_port
  import pit_pkg::*;
#(
  parameter int unsigned COUNTER_ID = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  counter_rw_port_if.slave     bus,
  input  logic [COUNT_W-1:0]   currentCount,
  input  logic                 out_pin,
  input  logic                 count_loaded,
  output logic [COUNT_W-1:0]   countreg,
  output logic                 newCount,
  output logic [2:0]           mode,
  output logic                 bcd,
  output logic                 ctrl_wr,
  output logic                 null_count
);

  localparam logic [1:0] ID = 2'(COUNTER_ID);

  logic [COUNT_W-1:0] r_countreg;
  logic               r_newCount;
  logic [2:0]         r_mode;
  logic               r_bcd;
  logic [1:0]         r_rw;
  logic               r_ctrl_wr;
  logic               r_null_count;
  logic [BYTE_W-1:0]  r_dout;
  logic [BYTE_W-1:0]  r_temp;
  logic               r_wptr;
  logic               r_rptr;
  logic [COUNT_W-1:0] r_ol;
  logic               r_cl_full;

  logic               w_wr, w_rd;
  logic [1:0]         w_sc, w_cw_rw;
  logic               w_ctrl_set, w_ctrl_latch, w_cnt_wr, w_cnt_rd, w_load;
  logic               w_rb_count, w_rb_status;
  logic               w_sl_full;
  logic [BYTE_W-1:0]  w_status_q;
  logic [BYTE_W-1:0]  w_rd_data;
  logic               w_rptr_nxt, w_rel_count, w_rel_status;
  logic [COUNT_W-1:0] w_src;

  // Bus decode: an access needs cs and exactly one of wr/rd.
  assign w_wr         = bus.cs & bus.wr & ~bus.rd;
  assign w_rd         = bus.cs & bus.rd & ~bus.wr;
  assign w_sc         = bus.din[CW_SC_HI:CW_SC_LO];
  assign w_cw_rw      = bus.din[CW_RW_HI:CW_RW_LO];
  assign w_ctrl_set   = w_wr & (bus.a == CTRL_ADDR) & (w_sc == ID) & (w_cw_rw != RW_LATCH);
  assign w_ctrl_latch = w_wr & (bus.a == CTRL_ADDR) & (w_sc == ID) & (w_cw_rw == RW_LATCH);
  assign w_cnt_wr     = w_wr & (bus.a == ID);
  assign w_cnt_rd     = w_rd & (bus.a == ID);
  assign w_load       = w_cnt_wr & ((r_rw == RW_LSB) | (r_rw == RW_MSB) | ((r_rw == RW_WORD) & r_wptr));

`ifdef PIT_READBACK_EN
  localparam int unsigned CNT_BIT = COUNTER_ID + 1;

  logic              r_sl_full;
  logic [BYTE_W-1:0] r_status;
  logic              w_rb_hit;

  assign w_rb_hit    = w_wr & (bus.a == CTRL_ADDR) & (w_sc == SC_READBACK) & bus.din[CNT_BIT];
  assign w_rb_count  = w_rb_hit & ~bus.din[CW_RW_HI];
  assign w_rb_status = w_rb_hit & ~bus.din[CW_RW_LO];
  assign w_sl_full   = r_sl_full;
  assign w_status_q  = r_status;

  // Status latch: snapshot on read-back, released by the next read of this counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sl_full <= 1'b0;
      r_status  <= '0;
    end else if (w_ctrl_set) begin
      r_sl_full <= 1'b0;
    end else if (w_rb_status && !r_sl_full) begin
      r_status  <= {out_pin, r_null_count, r_rw, r_mode, r_bcd};
      r_sl_full <= 1'b1;
    end else if (w_cnt_rd && r_sl_full) begin
      r_sl_full <= 1'b0;
    end
  end
`else
  logic w_unused_ok;

  assign w_rb_count  = 1'b0;
  assign w_rb_status = 1'b0;
  assign w_sl_full   = 1'b0;
  assign w_status_q  = '0;
  assign w_unused_ok = out_pin;
`endif

  // Read data select: status latch, then count latch, then live count.
  always_comb begin
    w_rd_data    = r_dout;
    w_rptr_nxt   = r_rptr;
    w_rel_count  = 1'b0;
    w_rel_status = 1'b0;
    w_src        = r_cl_full ? r_ol : currentCount;
    if (w_sl_full) begin
      w_rd_data    = w_status_q;
      w_rel_status = 1'b1;
    end else begin
      unique case (r_rw)
        RW_MSB: begin
          w_rd_data   = w_src[15:8];
          w_rel_count = r_cl_full;
        end
        RW_WORD: begin
          w_rd_data   = r_rptr ? w_src[15:8] : w_src[7:0];
          w_rptr_nxt  = ~r_rptr;
          w_rel_count = r_cl_full & r_rptr;
        end
        default: begin
          w_rd_data   = w_src[7:0];
          w_rel_count = r_cl_full;
        end
      endcase
    end
  end

  // Control, count-write, counter-latch and read state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_countreg   <= '0;
      r_newCount   <= 1'b0;
      r_mode       <= 3'd0;
      r_bcd        <= 1'b0;
      r_rw         <= RW_LSB;
      r_ctrl_wr    <= 1'b0;
      r_null_count <= 1'b1;
      r_dout       <= '0;
      r_temp       <= '0;
      r_wptr       <= 1'b0;
      r_rptr       <= 1'b0;
      r_ol         <= '0;
      r_cl_full    <= 1'b0;
    end else begin
      r_newCount <= w_load;
      r_ctrl_wr  <= w_ctrl_set;
      if (count_loaded) r_null_count <= 1'b0;
      if (w_load)       r_null_count <= 1'b1;

      if (w_ctrl_set) begin
        r_rw         <= w_cw_rw;
        r_mode       <= fold_mode(bus.din[CW_M_HI:CW_M_LO]);
        r_bcd        <= bus.din[CW_BCD];
        r_wptr       <= 1'b0;
        r_rptr       <= 1'b0;
        r_cl_full    <= 1'b0;
        r_null_count <= 1'b1;
      end

      if ((w_ctrl_latch || w_rb_count) && !r_cl_full) begin
        r_ol      <= currentCount;
        r_cl_full <= 1'b1;
      end

      if (w_cnt_wr) begin
        unique case (r_rw)
          RW_LSB: r_countreg <= {8'h00, bus.din};
          RW_MSB: r_countreg <= {bus.din, 8'h00};
          RW_WORD: begin
            if (!r_wptr) begin
              r_temp <= bus.din;
              r_wptr <= 1'b1;
            end else begin
              r_countreg <= {bus.din, r_temp};
              r_wptr     <= 1'b0;
            end
          end
          default: ;
        endcase
      end

      if (w_cnt_rd) begin
        r_dout <= w_rd_data;
        if (!w_rel_status) r_rptr <= w_rptr_nxt;
        if (w_rel_count)   r_cl_full <= 1'b0;
      end
    end
  end

  assign bus.dout   = r_dout;
  assign countreg   = r_countreg;
  assign newCount   = r_newCount;
  assign mode       = r_mode;
  assign bcd        = r_bcd;
  assign ctrl_wr    = r_ctrl_wr;
  assign null_count = r_null_count;

endmodule

// File: tb/tb_counter_rw_port.sv
// Directed bench for counter_rw_port (counter 0); read-back cases follow PIT_READBACK_EN.
module tb_counter_rw_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] currentCount;
  logic        out_pin;
  logic        count_loaded;
  logic [15:0] countreg;
  logic        newCount;
  logic [2:0]  mode;
  logic        bcd;
  logic        ctrl_wr;
  logic        null_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] rdata;

  counter_rw_port_if bus_if ();

  counter_rw_port #(.COUNTER_ID(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if),
    .currentCount (currentCount),
    .out_pin      (out_pin),
    .count_loaded (count_loaded),
    .countreg     (countreg),
    .newCount     (newCount),
    .mode         (mode),
    .bcd          (bcd),
    .ctrl_wr      (ctrl_wr),
    .null_count   (null_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [1:0] addr, input logic [7:0] data);
    bus_if.cs = 1'b1; bus_if.wr = 1'b1; bus_if.a = addr; bus_if.din = data;
    tick();
    bus_if.cs = 1'b0; bus_if.wr = 1'b0;
  endtask

  task automatic cpu_rd(input logic [1:0] addr, output logic [7:0] data);
    bus_if.cs = 1'b1; bus_if.rd = 1'b1; bus_if.a = addr;
    tick();
    bus_if.cs = 1'b0; bus_if.rd = 1'b0;
    data = bus_if.dout;
  endtask

  task automatic pulse_loaded();
    count_loaded = 1'b1;
    tick();
    count_loaded = 1'b0;
  endtask

  initial begin
    rst = 1'b1; currentCount = 16'h0000; out_pin = 1'b0; count_loaded = 1'b0;
    bus_if.cs = 1'b0; bus_if.wr = 1'b0; bus_if.rd = 1'b0; bus_if.a = 2'b00; bus_if.din = 8'h00;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_countreg", countreg, 16'h0000);
    check("rst_newCount", 16'(newCount), 16'h0);
    check("rst_mode", 16'(mode), 16'h0);
    check("rst_bcd", 16'(bcd), 16'h0);
    check("rst_ctrl_wr", 16'(ctrl_wr), 16'h0);
    check("rst_null", 16'(null_count), 16'h1);
    check("rst_dout", 16'(bus_if.dout), 16'h00);

    // Reset RW is LSB-only
    cpu_wr(2'd0, 8'h3C);
    check("rwrst_countreg", countreg, 16'h003C);
    check("rwrst_newCount", 16'(newCount), 16'h1);

    // 8'h32: RW=11 mode 1, word 0x0004
    cpu_wr(2'd3, 8'h32);
    check("c32_ctrl_wr", 16'(ctrl_wr), 16'h1);
    check("c32_mode", 16'(mode), 16'h1);
    check("c32_null", 16'(null_count), 16'h1);
    cpu_wr(2'd0, 8'h04);
    check("lsb_no_pulse", 16'(newCount), 16'h0);
    check("lsb_countreg_hold", countreg, 16'h003C);
    cpu_wr(2'd0, 8'h00);
    check("word_countreg", countreg, 16'h0004);
    check("word_newCount", 16'(newCount), 16'h1);
    tick();
    check("newCount_width", 16'(newCount), 16'h0);
    check("null_before_load", 16'(null_count), 16'h1);
    pulse_loaded();
    check("null_after_load", 16'(null_count), 16'h0);

    // 8'h12: RW=01
    cpu_wr(2'd3, 8'h12);
    check("c12_null", 16'(null_count), 16'h1);
    cpu_wr(2'd0, 8'hA5);
    check("lsb_A5", countreg, 16'h00A5);
    check("lsb_A5_pulse", 16'(newCount), 16'h1);
    count_loaded = 1'b1;
    cpu_wr(2'd0, 8'h5A);
    count_loaded = 1'b0;
    check("lsb_5A", countreg, 16'h005A);
    check("lsb_5A_pulse", 16'(newCount), 16'h1);
    check("null_coincide", 16'(null_count), 16'h1);

    // 8'h22: RW=10
    cpu_wr(2'd3, 8'h22);
    cpu_wr(2'd0, 8'h7E);
    check("msb_7E", countreg, 16'h7E00);

    // Counter latch with RW=11; second latch command ignored while full
    cpu_wr(2'd3, 8'h30);
    currentCount = 16'h1234;
    cpu_wr(2'd3, 8'h00);
    check("latch_no_ctrl_wr", 16'(ctrl_wr), 16'h0);
    check("latch_mode_kept", 16'(mode), 16'h0);
    currentCount = 16'h1200;
    cpu_wr(2'd3, 8'h00);
    currentCount = 16'h1200;
    cpu_rd(2'd0, rdata); check("latch_lsb", 16'(rdata), 16'h0034);
    cpu_rd(2'd0, rdata); check("latch_msb", 16'(rdata), 16'h0012);
    cpu_rd(2'd0, rdata); check("live_lsb", 16'(rdata), 16'h0000);
    cpu_rd(2'd0, rdata); check("live_msb", 16'(rdata), 16'h0012);
    cpu_rd(2'd3, rdata); check("rd_ctrl_hold", 16'(rdata), 16'h0012);

    // Control word between LSB and MSB discards the LSB
    cpu_wr(2'd0, 8'h77);
    cpu_wr(2'd3, 8'h36);
    check("c36_mode", 16'(mode), 16'h3);
    cpu_wr(2'd0, 8'h10);
    cpu_wr(2'd0, 8'h00);
    check("discard_countreg", countreg, 16'h0010);

    // Mode 6/7 fold, BCD flag, other-counter control ignored
    cpu_wr(2'd3, 8'h3C);
    check("mode6_fold", 16'(mode), 16'h2);
    cpu_wr(2'd3, 8'h3F);
    check("mode7_fold", 16'(mode), 16'h3);
    check("bcd_set", 16'(bcd), 16'h1);
    cpu_wr(2'd3, 8'h72);
    check("other_ctr_ctrl_wr", 16'(ctrl_wr), 16'h0);
    check("other_ctr_mode", 16'(mode), 16'h3);

    // cs=0 and wr&rd together are ignored
    bus_if.cs = 1'b0; bus_if.wr = 1'b1; bus_if.a = 2'd0; bus_if.din = 8'hFF;
    tick();
    bus_if.wr = 1'b0;
    check("cs0_countreg", countreg, 16'h0010);
    check("cs0_newCount", 16'(newCount), 16'h0);
    bus_if.cs = 1'b1; bus_if.wr = 1'b1; bus_if.rd = 1'b1; bus_if.a = 2'd0; bus_if.din = 8'hFF;
    tick();
    bus_if.cs = 1'b0; bus_if.wr = 1'b0; bus_if.rd = 1'b0;
    check("wrrd_countreg", countreg, 16'h0010);
    check("wrrd_newCount", 16'(newCount), 16'h0);
    check("wrrd_dout", 16'(bus_if.dout), 16'h0012);
    cpu_wr(2'd0, 8'h34);
    cpu_wr(2'd0, 8'h12);
    check("wptr_intact", countreg, 16'h1234);

    // Reset between LSB and MSB
    cpu_wr(2'd0, 8'h99);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_countreg", countreg, 16'h0000);
    check("midrst_mode", 16'(mode), 16'h0);
    check("midrst_null", 16'(null_count), 16'h1);
    check("midrst_dout", 16'(bus_if.dout), 16'h0000);
    cpu_wr(2'd3, 8'h30);
    cpu_wr(2'd0, 8'h11);
    cpu_wr(2'd0, 8'h22);
    check("midrst_word", countreg, 16'h2211);

`ifdef PIT_READBACK_EN
    // Read-back latch-both: status, then count LSB, MSB
    cpu_wr(2'd3, 8'h32);
    cpu_wr(2'd0, 8'h04);
    cpu_wr(2'd0, 8'h00);
    pulse_loaded();
    out_pin = 1'b1;
    currentCount = 16'hABCD;
    cpu_wr(2'd3, 8'hC2);
    currentCount = 16'h0000;
    cpu_rd(2'd0, rdata); check("rb_status", 16'(rdata), 16'h00B2);
    cpu_rd(2'd0, rdata); check("rb_cnt_lsb", 16'(rdata), 16'h00CD);
    cpu_rd(2'd0, rdata); check("rb_cnt_msb", 16'(rdata), 16'h00AB);
    cpu_rd(2'd0, rdata); check("rb_live", 16'(rdata), 16'h0000);
`else
    // Without read-back, SC=11 writes do nothing
    currentCount = 16'hABCD;
    cpu_wr(2'd3, 8'hC2);
    check("sc3_ctrl_wr", 16'(ctrl_wr), 16'h0);
    check("sc3_mode", 16'(mode), 16'h0);
    currentCount = 16'h0000;
    cpu_rd(2'd0, rdata); check("sc3_live_lsb", 16'(rdata), 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
